// File: rtl/aes_bist_engine_pkg.sv
// Shared definitions for the aes BIST engine.
//   AES_BLOCK_W        : aes block / key width
//   AES_BIST_LFSR_POLY : feedback taps of x^128 + x^7 + x^2 + x + 1 (x^128 term implicit)
//   aes_bist_state_t   : sequencer FSM states
//   lfsr_next()        : one Galois step, shift towards the MSB
package aes_bist_engine_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  localparam logic [AES_BLOCK_W-1:0] AES_BIST_LFSR_POLY = 128'h87;

  typedef enum logic [2:0] {
    StIdle,
    StEncGo,
    StEncWait,
    StDecGo,
    StDecWait,
    StCheck,
    StDone
  } aes_bist_state_t;

  function automatic logic [AES_BLOCK_W-1:0] lfsr_next(input logic [AES_BLOCK_W-1:0] s);
    return {s[AES_BLOCK_W-2:0], 1'b0} ^ (s[AES_BLOCK_W-1] ? AES_BIST_LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/aes_bist_engine_if.sv
// Encryption/decryption handshake between the BIST engine and the aes core.
//   master : BIST side (drives start pulses, plaintext, key, ciphertext for decryption)
//   slave  : core side (returns ciphertext, decrypted plaintext and done strobes)
interface aes_bist_engine_if;
  import aes_bist_engine_pkg::*;

  logic                   start_encryption;
  logic [AES_BLOCK_W-1:0] plaintext_encryption;
  logic [AES_BLOCK_W-1:0] key_encryption;
  logic [AES_BLOCK_W-1:0] cyphertext_encryption;
  logic                   done_encryption;
  logic                   start_decryption;
  logic [AES_BLOCK_W-1:0] cyphertext_decryption;
  logic [AES_BLOCK_W-1:0] plaintext_decryption;
  logic                   done_decyption;

  modport master (
    output start_encryption, plaintext_encryption, key_encryption,
    output start_decryption, cyphertext_decryption,
    input  cyphertext_encryption, done_encryption,
    input  plaintext_decryption, done_decyption
  );

  modport slave (
    input  start_encryption, plaintext_encryption, key_encryption,
    input  start_decryption, cyphertext_decryption,
    output cyphertext_encryption, done_encryption,
    output plaintext_decryption, done_decyption
  );

endinterface

// File: rtl/aes_bist_lfsr.sv
// 128-bit Galois LFSR producing the BIST plaintext sequence.
//   clk, rst : clock, async active-low reset (state returns to the seed)
//   load     : reload the seed (takes priority over step)
//   step     : advance one step
//   state    : current plaintext
// A zero SEED would lock the LFSR, so it is replaced by 1.
module aes_bist_lfsr
  import aes_bist_engine_pkg::*;
#(
  parameter logic [AES_BLOCK_W-1:0] SEED = 128'h00000101030307070f0f1f1f3f3f7f7f
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  output logic [AES_BLOCK_W-1:0] state
);

  localparam logic [AES_BLOCK_W-1:0] SeedEff = (SEED == '0) ? 128'h1 : SEED;

  logic [AES_BLOCK_W-1:0] state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SeedEff;
    end else if (load) begin
      state_q <= SeedEff;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/aes_bist_engine.sv
// Self-test sequencer for the aes core: for each of NUM_VECTORS LFSR plaintexts it encrypts,
// decrypts the returned ciphertext and compares with the original.
//   clk, rst             : clock, async active-low reset
//   start, key_in        : run request (accepted in idle/done), key latched on acceptance
//   busy, done, pass     : run status; done is a level held until the next accepted start
//   timeout              : core failed to answer within TIMEOUT_CYCLES
//   err_count, vec_count : mismatching / checked vector counts
//   core                 : handshake to the aes core (master side)
// Optional build macro AES_BIST_FAIL_CAPTURE_EN adds fail_valid, fail_index and fail_plaintext,
// which hold the first mismatching vector of the run (timeouts are not captured).
module aes_bist_engine
  import aes_bist_engine_pkg::*;
#(
  parameter int unsigned            NUM_VECTORS    = 16,
  parameter int unsigned            TIMEOUT_CYCLES = 1024,
  parameter logic [AES_BLOCK_W-1:0] SEED           = 128'h00000101030307070f0f1f1f3f3f7f7f
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [AES_BLOCK_W-1:0]             key_in,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   err_count,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
`ifdef AES_BIST_FAIL_CAPTURE_EN
  output logic                               fail_valid,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   fail_index,
  output logic [AES_BLOCK_W-1:0]             fail_plaintext,
`endif
  aes_bist_engine_if.master                  core
);

  localparam int unsigned CW = $clog2(NUM_VECTORS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  aes_bist_state_t        state_q, state_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] ct_q, ct_d;
  logic [AES_BLOCK_W-1:0] ptd_q, ptd_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          err_q, err_d;
  logic [CW-1:0]          vec_q, vec_d;
  logic                   timeout_q, timeout_d;
  logic [CW-1:0]          err_inc, vec_inc;
  logic                   lfsr_load, lfsr_adv, mismatch, timer_exp;
  logic [AES_BLOCK_W-1:0] lfsr_state;

`ifdef AES_BIST_FAIL_CAPTURE_EN
  logic                   fvalid_q, fvalid_d;
  logic [CW-1:0]          findex_q, findex_d;
  logic [AES_BLOCK_W-1:0] fpt_q, fpt_d;
`endif

  aes_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_adv),
    .state (lfsr_state)
  );

  assign err_inc   = (err_q == CW'(NUM_VECTORS)) ? err_q : err_q + CW'(1);
  assign vec_inc   = vec_q + CW'(1);
  assign mismatch  = (ptd_q != lfsr_state);
  assign timer_exp = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ct_d      = ct_q;
    ptd_d     = ptd_q;
    timer_d   = timer_q;
    err_d     = err_q;
    vec_d     = vec_q;
    timeout_d = timeout_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
`ifdef AES_BIST_FAIL_CAPTURE_EN
    fvalid_d  = fvalid_q;
    findex_d  = findex_q;
    fpt_d     = fpt_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          key_d     = key_in;
          err_d     = '0;
          vec_d     = '0;
          timeout_d = 1'b0;
          lfsr_load = 1'b1;
`ifdef AES_BIST_FAIL_CAPTURE_EN
          fvalid_d  = 1'b0;
          findex_d  = '0;
          fpt_d     = '0;
`endif
          state_d   = StEncGo;
        end
      end
      StEncGo: begin
        timer_d = '0;
        state_d = StEncWait;
      end
      StEncWait: begin
        // A core answer in the final timer cycle still wins over the timeout.
        if (core.done_encryption) begin
          ct_d    = core.cyphertext_encryption;
          state_d = StDecGo;
        end else if (timer_exp) begin
          timeout_d = 1'b1;
          err_d     = err_inc;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StDecGo: begin
        timer_d = '0;
        state_d = StDecWait;
      end
      StDecWait: begin
        if (core.done_decyption) begin
          ptd_d   = core.plaintext_decryption;
          state_d = StCheck;
        end else if (timer_exp) begin
          timeout_d = 1'b1;
          err_d     = err_inc;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_inc;
`ifdef AES_BIST_FAIL_CAPTURE_EN
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            findex_d = vec_q;
            fpt_d    = lfsr_state;
          end
`endif
        end
        vec_d    = vec_inc;
        lfsr_adv = 1'b1;
        state_d  = (vec_inc == CW'(NUM_VECTORS)) ? StDone : StEncGo;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      ct_q      <= '0;
      ptd_q     <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      vec_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      ct_q      <= ct_d;
      ptd_q     <= ptd_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      vec_q     <= vec_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef AES_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fvalid_q <= 1'b0;
      findex_q <= '0;
      fpt_q    <= '0;
    end else begin
      fvalid_q <= fvalid_d;
      findex_q <= findex_d;
      fpt_q    <= fpt_d;
    end
  end

  assign fail_valid     = fvalid_q;
  assign fail_index     = findex_q;
  assign fail_plaintext = fpt_q;
`endif

  // All outputs decode registered state, so reset clears them (and the core pulses) at once.
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0) && !timeout_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

  assign core.start_encryption      = (state_q == StEncGo);
  assign core.start_decryption      = (state_q == StDecGo);
  // The LFSR resets to SEED, so the bus is gated to read zero outside a run.
  assign core.plaintext_encryption  = busy ? lfsr_state : '0;
  assign core.key_encryption        = key_q;
  assign core.cyphertext_decryption = ct_q;

endmodule

// File: tb/tb_aes_bist_engine.sv
// Bench for aes_bist_engine with a reversible stand-in core (configurable latency, corruption,
// hang) plus a second instance with SEED=0 on a one-cycle loopback core.
module tb_aes_bist_engine;

  localparam int unsigned NV = 4;
  localparam int unsigned TO = 64;
  localparam logic [127:0] SEED_M = 128'h00000101030307070f0f1f1f3f3f7f7f;
  localparam logic [127:0] MIX    = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

  logic clk = 1'b0;
  logic rst;
  logic start, zstart;
  logic [127:0] key_in;
  logic busy, done, pass, timeout;
  logic [2:0] err_count, vec_count;
  logic z_busy, z_done, z_pass, z_timeout;
  logic [2:0] z_err, z_vec;
`ifdef AES_BIST_FAIL_CAPTURE_EN
  logic fail_valid, z_fvalid;
  logic [2:0] fail_index, z_findex;
  logic [127:0] fail_plaintext, z_fpt;
`endif

  aes_bist_engine_if bus ();
  aes_bist_engine_if zbus ();

  always #5 clk = ~clk;

  aes_bist_engine #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO), .SEED(SEED_M)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .vec_count(vec_count),
`ifdef AES_BIST_FAIL_CAPTURE_EN
    .fail_valid(fail_valid), .fail_index(fail_index), .fail_plaintext(fail_plaintext),
`endif
    .core(bus)
  );

  aes_bist_engine #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO), .SEED(128'h0)) dut_z (
    .clk(clk), .rst(rst), .start(zstart), .key_in(key_in), .busy(z_busy), .done(z_done),
    .pass(z_pass), .timeout(z_timeout), .err_count(z_err), .vec_count(z_vec),
`ifdef AES_BIST_FAIL_CAPTURE_EN
    .fail_valid(z_fvalid), .fail_index(z_findex), .fail_plaintext(z_fpt),
`endif
    .core(zbus)
  );

  function automatic logic [127:0] enc_f(input logic [127:0] p, input logic [127:0] k);
    return {p[63:0], p[127:64]} ^ k ^ MIX;
  endfunction

  function automatic logic [127:0] dec_f(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] t;
    t = c ^ k ^ MIX;
    return {t[63:0], t[127:64]};
  endfunction

  // x^128 + x^7 + x^2 + x + 1, shifting towards the MSB
  function automatic logic [127:0] nth(input logic [127:0] s, input int n);
    logic [127:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    return v;
  endfunction

  // Stand-in core configuration, written only by the stimulus process.
  int enc_lat, dec_lat, enc_hang, dec_hang;
  logic [3:0] corrupt;

  int enc_n, dec_n, enc_cnt, dec_cnt;
  logic enc_act, dec_act, dec_bad;
  logic [127:0] enc_pt, dec_ct;
  logic [127:0] pt_log [16];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.done_encryption <= 1'b0;
      bus.done_decyption <= 1'b0;
      bus.cyphertext_encryption <= '0;
      bus.plaintext_decryption <= '0;
      enc_n <= 0; dec_n <= 0; enc_cnt <= 0; dec_cnt <= 0;
      enc_act <= 1'b0; dec_act <= 1'b0; dec_bad <= 1'b0;
      enc_pt <= '0; dec_ct <= '0;
    end else begin
      bus.done_encryption <= 1'b0;
      bus.done_decyption <= 1'b0;
      if (bus.start_encryption) begin
        pt_log[enc_n[3:0]] <= bus.plaintext_encryption;
        enc_n <= enc_n + 1;
        if (enc_n != enc_hang) begin
          if (enc_lat == 0) begin
            bus.done_encryption <= 1'b1;
            bus.cyphertext_encryption <= enc_f(bus.plaintext_encryption, bus.key_encryption);
          end else begin
            enc_act <= 1'b1; enc_cnt <= enc_lat; enc_pt <= bus.plaintext_encryption;
          end
        end
      end else if (enc_act) begin
        if (enc_cnt == 1) begin
          bus.done_encryption <= 1'b1;
          bus.cyphertext_encryption <= enc_f(enc_pt, bus.key_encryption);
          enc_act <= 1'b0;
        end else enc_cnt <= enc_cnt - 1;
      end
      if (bus.start_decryption) begin
        dec_n <= dec_n + 1;
        if (dec_n != dec_hang) begin
          if (dec_lat == 0) begin
            bus.done_decyption <= 1'b1;
            bus.plaintext_decryption <= dec_f(bus.cyphertext_decryption, bus.key_encryption)
                                        ^ {127'b0, corrupt[dec_n[1:0]]};
          end else begin
            dec_act <= 1'b1; dec_cnt <= dec_lat; dec_ct <= bus.cyphertext_decryption;
            dec_bad <= corrupt[dec_n[1:0]];
          end
        end
      end else if (dec_act) begin
        if (dec_cnt == 1) begin
          bus.done_decyption <= 1'b1;
          bus.plaintext_decryption <= dec_f(dec_ct, bus.key_encryption) ^ {127'b0, dec_bad};
          dec_act <= 1'b0;
        end else dec_cnt <= dec_cnt - 1;
      end
    end
  end

  // Loopback core for the SEED=0 instance.
  int z_n;
  logic [127:0] z_log [8];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      zbus.done_encryption <= 1'b0; zbus.done_decyption <= 1'b0;
      zbus.cyphertext_encryption <= '0; zbus.plaintext_decryption <= '0;
      z_n <= 0;
    end else begin
      zbus.done_encryption <= zbus.start_encryption;
      zbus.cyphertext_encryption <= zbus.plaintext_encryption;
      zbus.done_decyption <= zbus.start_decryption;
      zbus.plaintext_decryption <= zbus.cyphertext_decryption;
      if (zbus.start_encryption) begin
        z_log[z_n[2:0]] <= zbus.plaintext_encryption;
        z_n <= z_n + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 1;
    ok = 1'b0;
    while (cyc < limit && !ok) begin
      tick();
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  typedef struct {
    int enc_lat; int dec_lat; logic [3:0] corrupt; int enc_hang; int dec_hang;
    logic [127:0] key;
    logic exp_pass; logic exp_to; int exp_err; int exp_vec; int exp_pulses; int max_cyc;
    int exp_fidx;
  } row_t;

  row_t tbl [8];
  int cyc;
  bit ok;

  initial begin
    tbl[0] = '{1, 1, 4'b0000, -1, -1, 128'h0, 1'b1, 1'b0, 0, 4, 4, 2000, -1};
    tbl[1] = '{3, 5, 4'b0000, -1, -1, 128'h000102030405060708090a0b0c0d0e0f,
               1'b1, 1'b0, 0, 4, 4, 2000, -1};
    tbl[2] = '{0, 0, 4'b0000, -1, -1, 128'hdeadbeef, 1'b1, 1'b0, 0, 4, 4, 2000, -1};
    tbl[3] = '{2, 1, 4'b0100, -1, -1, 128'h0, 1'b0, 1'b0, 1, 4, 4, 2000, 2};
    tbl[4] = '{1, 0, 4'b1001, -1, -1, 128'h77, 1'b0, 1'b0, 2, 4, 4, 2000, 0};
    tbl[5] = '{1, 1, 4'b0000, 0, -1, 128'h0, 1'b0, 1'b1, 1, 0, 1, 70, -1};
    tbl[6] = '{1, 1, 4'b0011, -1, 3, 128'h0, 1'b0, 1'b1, 3, 3, 4, 2000, 0};
    tbl[7] = '{4, 2, 4'b0000, 2, -1, 128'h5, 1'b0, 1'b1, 1, 2, 3, 2000, -1};

    rst = 1'b0; start = 1'b0; zstart = 1'b0; key_in = '0;
    enc_lat = 1; dec_lat = 1; enc_hang = -1; dec_hang = -1; corrupt = '0;
    tick(); tick();

    // Outputs while held in reset
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_pass", 128'(pass), 128'h0);
    chk("rst_timeout", 128'(timeout), 128'h0);
    chk("rst_err", 128'(err_count), 128'h0);
    chk("rst_vec", 128'(vec_count), 128'h0);
    chk("rst_start_enc", 128'(bus.start_encryption), 128'h0);
    chk("rst_start_dec", 128'(bus.start_decryption), 128'h0);
    chk("rst_pt_enc", bus.plaintext_encryption, 128'h0);
    chk("rst_key_enc", bus.key_encryption, 128'h0);
    chk("rst_ct_dec", bus.cyphertext_decryption, 128'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      enc_lat = tbl[i].enc_lat; dec_lat = tbl[i].dec_lat; corrupt = tbl[i].corrupt;
      enc_hang = tbl[i].enc_hang; dec_hang = tbl[i].dec_hang; key_in = tbl[i].key;
      do_reset();
      pulse_start();
      chk($sformatf("row%0d_busy_run", i), 128'(busy), 128'h1);
      wait_done(2000, cyc, ok);
      chk($sformatf("row%0d_done", i), 128'(ok), 128'h1);
      chk($sformatf("row%0d_cycles_in_bound", i), 128'(cyc <= tbl[i].max_cyc), 128'h1);
      chk($sformatf("row%0d_busy", i), 128'(busy), 128'h0);
      chk($sformatf("row%0d_pass", i), 128'(pass), 128'(tbl[i].exp_pass));
      chk($sformatf("row%0d_timeout", i), 128'(timeout), 128'(tbl[i].exp_to));
      chk($sformatf("row%0d_err", i), 128'(err_count), 128'(tbl[i].exp_err));
      chk($sformatf("row%0d_vec", i), 128'(vec_count), 128'(tbl[i].exp_vec));
      chk($sformatf("row%0d_pulses", i), 128'(enc_n), 128'(tbl[i].exp_pulses));
      chk($sformatf("row%0d_key", i), bus.key_encryption, tbl[i].key);
      for (int k = 0; k < tbl[i].exp_pulses; k++)
        chk($sformatf("row%0d_pt%0d", i, k), pt_log[k], nth(SEED_M, k));
`ifdef AES_BIST_FAIL_CAPTURE_EN
      chk($sformatf("row%0d_fvalid", i), 128'(fail_valid), 128'(tbl[i].exp_fidx >= 0));
      if (tbl[i].exp_fidx >= 0) begin
        chk($sformatf("row%0d_findex", i), 128'(fail_index), 128'(tbl[i].exp_fidx));
        chk($sformatf("row%0d_fpt", i), fail_plaintext, nth(SEED_M, tbl[i].exp_fidx));
      end
`endif
      // done is a level: still held a few cycles later
      tick(); tick();
      chk($sformatf("row%0d_done_held", i), 128'(done), 128'h1);
    end

    // start re-pulsed while busy is ignored
    enc_lat = 10; dec_lat = 3; corrupt = '0; enc_hang = -1; dec_hang = -1; key_in = 128'h99;
    do_reset();
    pulse_start();
    tick(); tick(); tick();
    pulse_start();
    chk("repulse_busy", 128'(busy), 128'h1);
    chk("repulse_done_low", 128'(done), 128'h0);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    pulse_start();
    wait_done(2000, cyc, ok);
    chk("repulse_done", 128'(ok), 128'h1);
    chk("repulse_vec", 128'(vec_count), 128'(NV));
    chk("repulse_pass", 128'(pass), 128'h1);
    chk("repulse_enc_pulses", 128'(enc_n), 128'(NV));
    chk("repulse_dec_pulses", 128'(dec_n), 128'(NV));

    // Reset dropped during DEC_WAIT
    enc_lat = 1; dec_lat = 30; key_in = 128'habcdef;
    do_reset();
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      tick();
      if (bus.start_decryption) ok = 1'b1;
    end
    chk("midrst_saw_dec_start", 128'(ok), 128'h1);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_done", 128'(done), 128'h0);
    chk("midrst_pass", 128'(pass), 128'h0);
    chk("midrst_start_dec", 128'(bus.start_decryption), 128'h0);
    chk("midrst_pt_enc", bus.plaintext_encryption, 128'h0);
    chk("midrst_key_enc", bus.key_encryption, 128'h0);
    chk("midrst_ct_dec", bus.cyphertext_decryption, 128'h0);
    tick();
    rst = 1'b1;
    dec_lat = 1;
    tick();
    pulse_start();
    wait_done(2000, cyc, ok);
    chk("midrst_rerun_done", 128'(ok), 128'h1);
    chk("midrst_rerun_pass", 128'(pass), 128'h1);
    chk("midrst_rerun_vec", 128'(vec_count), 128'(NV));
    chk("midrst_rerun_pt0", pt_log[0], SEED_M);

    // SEED=0 instance: two back-to-back runs without reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      zstart = 1'b1;
      tick();
      zstart = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
        tick();
        if (z_done) ok = 1'b1;
      end
      chk($sformatf("seed0_run%0d_done", r), 128'(ok), 128'h1);
      chk($sformatf("seed0_run%0d_pass", r), 128'(z_pass), 128'h1);
      chk($sformatf("seed0_run%0d_busy", r), 128'(z_busy), 128'h0);
      chk($sformatf("seed0_run%0d_vec", r), 128'(z_vec), 128'(NV));
      chk($sformatf("seed0_run%0d_err", r), 128'(z_err), 128'h0);
      chk($sformatf("seed0_run%0d_timeout", r), 128'(z_timeout), 128'h0);
`ifdef AES_BIST_FAIL_CAPTURE_EN
      chk($sformatf("seed0_run%0d_fvalid", r), 128'(z_fvalid), 128'h0);
      chk($sformatf("seed0_run%0d_findex", r), 128'(z_findex), 128'h0);
      chk($sformatf("seed0_run%0d_fpt", r), z_fpt, 128'h0);
`endif
    end
    chk("seed0_first_pt", z_log[0], 128'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("seed0_run0_pt%0d", k), z_log[k], nth(128'h1, k));
      chk($sformatf("seed0_run1_pt%0d", k), z_log[k+4], nth(128'h1, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
